iobus_regfile_slave: RTL

Responder end of the MicroBlaze MCS IO bus: decodes strobed bus cycles aimed at its address window and serves them from a bank of 32-bit read/write registers. It accepts one transfer at a time, honours byte enables on writes, and answers every accepted transfer with a single-cycle `io_ready` after a parameterised number of wait states. Register contents are exported in parallel to fabric logic. It sits beside other IO-bus slaves behind the MCS IO bus.

---
 rtl/iobus_regfile_slave.sv | 93 +++++++++
 1 files changed

// File: rtl/iobus_regfile_slave.sv
// iobus_regfile_slave: MCS IO-bus responder serving a bank of byte-writable 32-bit registers
module iobus_regfile_slave #(
  parameter logic [31:0] BASE_ADDR   = 32'hC000_0000,
  parameter int          ADDR_BITS   = 3,
  parameter int          WAIT_CYCLES = 0,
  parameter logic [31:0] RESET_VAL   = 32'h0000_0000,
  localparam int         NUM_REGS    = 2 ** ADDR_BITS
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     io_addr_strobe,
  input  logic                     io_read_strobe,
  input  logic                     io_write_strobe,
  input  logic [3:0]               io_byte_en,
  input  logic [31:0]              io_addr,
  input  logic [31:0]              io_write_data,
  output logic [31:0]              io_read_data,
  output logic                     io_ready,
  output logic [32*NUM_REGS-1:0]   regs_out,
  output logic                     protocol_err
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t                      state_q, state_d;
  logic [3:0]                  cnt_q, cnt_d, be_q, be_d;
  logic [ADDR_BITS-1:0]        idx_q, idx_d;
  logic                        wr_q, wr_d, ready_q, ready_d, err_q, err_d;
  logic [31:0]                 wdata_q, wdata_d, rdata_q, rdata_d;
  logic [NUM_REGS-1:0][31:0]   regs_q, regs_d;
  logic                        hit, accept, unused_ok;
  assign unused_ok = ^io_addr[1:0];
  assign hit    = io_addr_strobe && io_addr[31:ADDR_BITS+2] == BASE_ADDR[31:ADDR_BITS+2];
  assign accept = state_q == IDLE && hit && (io_read_strobe ^ io_write_strobe);
  // The *_d transfer fields hold the live request on accept and the latched one afterwards,
  // so the commit below serves both the zero-wait and the waited path.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wr_d    = wr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    if (accept) begin
      idx_d   = io_addr[ADDR_BITS+1:2];
      wr_d    = io_write_strobe;
      be_d    = io_byte_en;
      wdata_d = io_write_data;
      state_d = WAIT_CYCLES == 0 ? RESP : WAIT;
      cnt_d   = 4'(WAIT_CYCLES);
    end
    if (state_q == WAIT) begin
      cnt_d   = cnt_q - 4'd1;
      state_d = cnt_q == 4'd1 ? RESP : WAIT;
    end
    if (state_q == RESP) state_d = IDLE;
    if ((state_q == IDLE && hit && io_read_strobe && io_write_strobe) ||
        (state_q != IDLE && io_addr_strobe)) err_d = 1'b1;
    ready_d = state_d == RESP;
    rdata_d = ready_d && !wr_d ? regs_q[idx_d] : 32'h0;
    regs_d  = regs_q;
    for (int b = 0; b < 4; b++)
      if (ready_d && wr_d && be_d[b]) regs_d[idx_d][8*b+:8] = wdata_d[8*b+:8];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      be_q    <= 4'd0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      regs_q  <= {NUM_REGS{RESET_VAL}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wr_q    <= wr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      regs_q  <= regs_d;
    end
  end
  assign io_ready     = ready_q;
  assign io_read_data = rdata_q;
  assign regs_out     = regs_q;
  assign protocol_err = err_q;
endmodule
